tanimoto_run_ctrl: RTL
======================

// Module: tanimoto_run_ctrl
// PURPOSE
//  Run sequencer in front of tanimoto_top. On i_Start it loads the comparator threshold table over the BRAM write port
//  from a config stream, then gates the vector stream into the pipeline, checks sub-vector framing and counts vectors.
//  It monitors ID-pair output handshakes until the final tlast, then pulses o_Done. Sits between the AXIS shell and tanimoto_top.
// PARAMETERS
//  BUS_WIDTH      128  vector stream beat width
//  SUB_VECTOR_NO  8    beats per vector (ceil(920/128))
//  CNT_WIDTH      10   threshold word width = BRAM addr/data width
//  THR_NO         16   threshold entries written per run (addr 0..THR_NO-1)
//  VCNT_WIDTH     16   width of vector / pair counters
// PORTS
//  clk             in   1           clock
//  rst             in   1           synchronous, active-high reset
//  i_Start         in   1           run request pulse; honoured only in IDLE
//  i_Cfg_Data      in   CNT_WIDTH   threshold word
//  i_Cfg_Valid     in   1           config beat valid
//  o_Cfg_Ready     out  1           config beat accepted (LOAD only)
//  o_BRAM_Addr     out  CNT_WIDTH   comparator BRAM address
//  o_BRAM_Din      out  CNT_WIDTH   comparator BRAM write data
//  o_BRAM_En       out  1           BRAM enable
//  o_BRAM_WrEn     out  1           BRAM write enable
//  i_Vector        in   BUS_WIDTH   upstream vector beat
//  i_Valid         in   1           upstream valid
//  i_Last          in   1           upstream last beat of run
//  o_Read          out  1           upstream ready
//  o_Vector        out  BUS_WIDTH   to tanimoto_top i_Vector
//  o_Valid         out  1           to tanimoto_top i_Valid
//  o_Last          out  1           to tanimoto_top i_Last
//  i_Read          in   1           tanimoto_top o_Read
//  i_Pair_Valid    in   1           monitored o_IDPair_Ready
//  i_Pair_Read     in   1           monitored downstream tready
//  i_Pair_Last     in   1           monitored o_IDPair_Last
//  o_Busy          out  1           state != IDLE
//  o_Done          out  1           1-cycle pulse at run end
//  o_Err           out  1           sticky framing error
//  o_VecCnt        out  VCNT_WIDTH  complete vectors forwarded this run
//  o_PairCnt       out  VCNT_WIDTH  ID pairs handshaken this run
// BEHAVIOUR
//  - Reset: state IDLE; all counters 0; all outputs 0 (o_Valid/o_Read/o_Last/o_Cfg_Ready/BRAM strobes/o_Done/o_Err = 0).
//  - States: IDLE -> LOAD -> RUN -> DRAIN -> DONE -> IDLE.
//  - IDLE: i_Start=1 -> LOAD; clears wr index, beat cnt, o_VecCnt, o_PairCnt, o_Err in the same edge.
//  - LOAD: o_Cfg_Ready=1. Accepted beat k registers one write the next cycle: En=WrEn=1, Addr=k, Din=data.
//    Write k=THR_NO-1 accepted -> RUN; o_Cfg_Ready drops the cycle after. BRAM strobes are 0 otherwise.
//  - RUN: combinational pass-through o_Vector=i_Vector, o_Valid=i_Valid, o_Last=i_Last, o_Read=i_Read.
//    All four are forced to 0 outside RUN. Beat accept = i_Valid & i_Read.
//    Beat cnt 0..SUB_VECTOR_NO-1 wraps; o_VecCnt += 1 on each wrap.
//    Accepted beat with i_Last -> DRAIN. If beat cnt != SUB_VECTOR_NO-1 on it, o_Err=1 (sticky until next Start).
//  - DRAIN: stream gated (o_Read=0). Wait for i_Pair_Valid & i_Pair_Read & i_Pair_Last -> DONE.
//  - DONE: o_Done=1 for exactly one cycle -> IDLE. Counters hold their values until the next Start.
//  - o_PairCnt += 1 per pair handshake in RUN or DRAIN. A tlast pair handshake during RUN is counted but ignored for exit.
//  - Counters saturate at all-ones; they do not wrap.
//  - i_Start outside IDLE is ignored. Config beats outside LOAD are not accepted.
//  - rst mid-run: next edge returns to IDLE with reset values. Any in-flight BRAM write is dropped (strobes 0).
//  - Latency: Start -> o_Cfg_Ready 1 cycle; last cfg beat -> RUN (o_Read live) 1 cycle; final pair -> o_Done 1 cycle.
// TESTING
//  1 Start, 16 cfg beats 100..115 with Valid held -> 16 BRAM writes at addr 0..15 with Din 100..115, 1 cycle after each accept.
//  2 Cfg with Valid toggled 0/1 and i_Read=0 in LOAD -> writes only on accepted beats, o_Read stays 0 until RUN.
//  3 RUN with 3 vectors (24 beats), Last on beat 24, random i_Read stalls -> o_VecCnt=3, o_Err=0; DRAIN entered.
//  4 Last on beat 13 -> o_Err=1, o_VecCnt=1. o_Err stays 1 through DONE and clears on the next Start.
//  5 DRAIN with 5 pairs, 5th carries Last, tready toggling -> o_PairCnt=5, o_Done one cycle after the 5th handshake; Start in RUN ignored.
//  6 rst asserted in RUN mid-vector -> next cycle IDLE, o_Valid/o_Read/o_Busy=0, counters 0.

Source files
------------

// File: rtl/tanimoto_run_ctrl.sv
// Run sequencer for tanimoto_top: loads the threshold BRAM from a config stream, gates and
// frames the vector stream, counts vectors and ID-pair handshakes, and pulses o_Done at run end.
module tanimoto_run_ctrl #(
  parameter int BUS_WIDTH     = 128,
  parameter int SUB_VECTOR_NO = 8,
  parameter int CNT_WIDTH     = 10,
  parameter int THR_NO        = 16,
  parameter int VCNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_Start,
  input  logic [CNT_WIDTH-1:0]  i_Cfg_Data,
  input  logic                  i_Cfg_Valid,
  output logic                  o_Cfg_Ready,
  output logic [CNT_WIDTH-1:0]  o_BRAM_Addr,
  output logic [CNT_WIDTH-1:0]  o_BRAM_Din,
  output logic                  o_BRAM_En,
  output logic                  o_BRAM_WrEn,
  input  logic [BUS_WIDTH-1:0]  i_Vector,
  input  logic                  i_Valid,
  input  logic                  i_Last,
  output logic                  o_Read,
  output logic [BUS_WIDTH-1:0]  o_Vector,
  output logic                  o_Valid,
  output logic                  o_Last,
  input  logic                  i_Read,
  input  logic                  i_Pair_Valid,
  input  logic                  i_Pair_Read,
  input  logic                  i_Pair_Last,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_Err,
  output logic [VCNT_WIDTH-1:0] o_VecCnt,
  output logic [VCNT_WIDTH-1:0] o_PairCnt
);

  localparam int BEAT_W = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;
  localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(SUB_VECTOR_NO - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_THR  = CNT_WIDTH'(THR_NO - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            r_state;
  logic [CNT_WIDTH-1:0]  r_wr_idx;
  logic [BEAT_W-1:0]     r_beat_cnt;
  logic [VCNT_WIDTH-1:0] r_vec_cnt;
  logic [VCNT_WIDTH-1:0] r_pair_cnt;
  logic                  r_err;
  logic                  r_bram_en;
  logic [CNT_WIDTH-1:0]  r_bram_addr;
  logic [CNT_WIDTH-1:0]  r_bram_din;

  logic w_run;
  logic w_beat_acc;
  logic w_pair_hs;

  assign w_run      = (r_state == S_RUN);
  assign w_beat_acc = w_run & i_Valid & i_Read;
  assign w_pair_hs  = i_Pair_Valid & i_Pair_Read;

  // Stream is a pure combinational pass-through in RUN and hard-gated to zero elsewhere.
  assign o_Vector    = w_run ? i_Vector : '0;
  assign o_Valid     = w_run & i_Valid;
  assign o_Last      = w_run & i_Last;
  assign o_Read      = w_run & i_Read;
  assign o_Cfg_Ready = (r_state == S_LOAD);
  assign o_Busy      = (r_state != S_IDLE);
  assign o_Done      = (r_state == S_DONE);
  assign o_Err       = r_err;
  assign o_VecCnt    = r_vec_cnt;
  assign o_PairCnt   = r_pair_cnt;
  assign o_BRAM_En   = r_bram_en;
  assign o_BRAM_WrEn = r_bram_en;
  assign o_BRAM_Addr = r_bram_addr;
  assign o_BRAM_Din  = r_bram_din;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_idx    <= '0;
      r_beat_cnt  <= '0;
      r_vec_cnt   <= '0;
      r_pair_cnt  <= '0;
      r_err       <= 1'b0;
      r_bram_en   <= 1'b0;
      r_bram_addr <= '0;
      r_bram_din  <= '0;
    end else begin
      // NOTE: the write strobe defaults low each cycle, so it is a single-cycle pulse per accepted beat.
      r_bram_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_Start) begin
            r_state    <= S_LOAD;
            r_wr_idx   <= '0;
            r_beat_cnt <= '0;
            r_vec_cnt  <= '0;
            r_pair_cnt <= '0;
            r_err      <= 1'b0;
          end
        end
        S_LOAD: begin
          if (i_Cfg_Valid) begin
            r_bram_en   <= 1'b1;
            r_bram_addr <= r_wr_idx;
            r_bram_din  <= i_Cfg_Data;
            r_wr_idx    <= r_wr_idx + 1'b1;
            if (r_wr_idx == LAST_THR) r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_beat_acc) begin
            if (r_beat_cnt == LAST_BEAT) begin
              r_beat_cnt <= '0;
              if (r_vec_cnt != '1) r_vec_cnt <= r_vec_cnt + 1'b1;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            if (i_Last) begin
              r_state <= S_DRAIN;
              if (r_beat_cnt != LAST_BEAT) r_err <= 1'b1;
            end
          end
          if (w_pair_hs && (r_pair_cnt != '1)) r_pair_cnt <= r_pair_cnt + 1'b1;
        end
        S_DRAIN: begin
          if (w_pair_hs) begin
            if (r_pair_cnt != '1) r_pair_cnt <= r_pair_cnt + 1'b1;
            if (i_Pair_Last) r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
